// File: rtl/bp_mem_resp_server.sv
// bp_mem_resp_server
//   Memory-side responder for the CCE memory-message interface. Accepts one command at a time,
//   services it against an internal block RAM after a fixed latency, and returns a response
//   carrying the echoed header plus read data.
//
//   Message layout (MSB..LSB): {msg_type[3:0], addr, size[2:0], payload, data}
//
//   Ports:
//     clk_i            clock
//     reset_n_i        asynchronous active-low reset
//     mem_cmd_i        command message
//     mem_cmd_v_i      command valid
//     mem_cmd_ready_o  command ready (high only in IDLE and out of reset)
//     mem_resp_o       response message, held stable while mem_resp_v_o is high
//     mem_resp_v_o     response valid
//     mem_resp_yumi_i  response consumed this cycle
//     error_o          sticky out-of-range error
//
//   Optional feature macro: BP_MEM_RESP_SERVER_RANGE_CHECK_EN
//     Defined:   addresses beyond the RAM are flagged, reads return 0, writes are dropped.
//     Undefined: error_o is tied low and the block index wraps modulo mem_els_p.
//
//   Timing: a command accepted at edge T raises mem_resp_v_o after edge T+latency_p for
//   latency_p >= 2 (WAIT lasts latency_p cycles). With latency_p == 1 the access is done on the
//   accept edge itself and the response is valid in the cycle right after the accept.
module bp_mem_resp_server #(
    parameter int unsigned paddr_width_p   = 40,
    parameter int unsigned block_width_p   = 512,
    parameter int unsigned payload_width_p = 12,
    parameter int unsigned mem_els_p       = 1024,
    parameter int unsigned latency_p       = 4,
    localparam int unsigned MsgW = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [MsgW-1:0] mem_cmd_i,
    input  logic            mem_cmd_v_i,
    output logic            mem_cmd_ready_o,
    output logic [MsgW-1:0] mem_resp_o,
    output logic            mem_resp_v_o,
    input  logic            mem_resp_yumi_i,
    output logic            error_o
);

    localparam int unsigned IdxW       = $clog2(mem_els_p);
    localparam int unsigned NBytes     = block_width_p / 8;
    localparam int unsigned CntW       = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int unsigned SizeLsb    = block_width_p + payload_width_p;
    localparam int unsigned AddrLsb    = SizeLsb + 3;
    localparam int unsigned TypeLsb    = AddrLsb + paddr_width_p;
    localparam bit          DirectResp = (latency_p == 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                   r_state;
    logic [CntW-1:0]          r_cnt;
    logic [MsgW-1:0]          r_cmd;
    logic [MsgW-1:0]          r_resp;
    logic [block_width_p-1:0] r_mem [mem_els_p];

    logic [MsgW-1:0]          w_acc_cmd;
    logic [3:0]               w_type;
    logic [2:0]               w_size;
    logic [2:0]               w_size_eff;
    logic [5:0]               w_off;
    logic [5:0]               w_mask;
    logic [5:0]               w_base;
    logic [IdxW-1:0]          w_idx;
    logic [block_width_p-1:0] w_data;
    logic [block_width_p-1:0] w_blk;
    logic [block_width_p-1:0] w_rd_data;
    logic [block_width_p-1:0] w_wr_blk;
    logic [block_width_p-1:0] w_resp_data;
    logic [MsgW-1:0]          w_resp;
    logic                     w_is_rd;
    logic                     w_is_wr;
    logic                     w_oor;
    logic                     w_accept;
    logic                     w_do_access;
    logic                     w_wr_en;

    assign mem_cmd_ready_o = reset_n_i && (r_state == StIdle);
    assign mem_resp_v_o    = (r_state == StResp);
    assign mem_resp_o      = r_resp;
    assign w_accept        = mem_cmd_v_i && mem_cmd_ready_o;

    // With latency 1 the access happens on the accept edge, so it works on the live command.
    assign w_acc_cmd = (r_state == StIdle) ? mem_cmd_i : r_cmd;

    assign w_type = w_acc_cmd[TypeLsb +: 4];
    assign w_size = w_acc_cmd[SizeLsb +: 3];
    assign w_off  = w_acc_cmd[AddrLsb +: 6];
    assign w_idx  = w_acc_cmd[AddrLsb+6 +: IdxW];
    assign w_data = w_acc_cmd[block_width_p-1:0];

    // rd = 0, wr = 1, uc_rd = 2, uc_wr = 3
    assign w_is_rd = (w_type == 4'd0) || (w_type == 4'd2);
    assign w_is_wr = (w_type == 4'd1) || (w_type == 4'd3);

    // Size 7 has no meaning on a 64 B block; treat it as a full-block access.
    assign w_size_eff = (w_size > 3'd6) ? 3'd6 : w_size;
    assign w_mask     = 6'((7'd1 << w_size_eff) - 7'd1);
    assign w_base     = w_off & ~w_mask;

    assign w_blk = r_mem[w_idx];

    assign w_do_access = reset_n_i &&
                         ((DirectResp && w_accept) || ((r_state == StWait) && (r_cnt == '0)));

    // Byte i of the read result is byte (base | (i mod n)) of the block, which replicates the
    // selected n bytes across the whole response. Writes touch only bytes inside the window.
    always_comb begin
        w_rd_data = '0;
        w_wr_blk  = w_blk;
        for (int i = 0; i < NBytes; i++) begin
            w_rd_data[i*8 +: 8] = w_blk[8*int'(w_base | (6'(i) & w_mask)) +: 8];
            if ((6'(i) & ~w_mask) == w_base) begin
                w_wr_blk[i*8 +: 8] = w_data[8*int'(6'(i) & w_mask) +: 8];
            end
        end
    end

    always_comb begin
        w_resp_data = '0;
        if (w_is_rd && !w_oor) begin
            w_resp_data = w_rd_data;
        end
    end

    assign w_resp  = {w_acc_cmd[MsgW-1:block_width_p], w_resp_data};
    assign w_wr_en = w_do_access && w_is_wr && !w_oor;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_resp  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cmd <= mem_cmd_i;
                        r_cnt <= CntW'(latency_p - 1);
                        if (DirectResp) begin
                            r_resp  <= w_resp;
                            r_state <= StResp;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        r_resp  <= w_resp;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (mem_resp_yumi_i) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Backing store is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_blk;
        end
    end

`ifdef BP_MEM_RESP_SERVER_RANGE_CHECK_EN
    logic r_error;

    assign w_oor = |w_acc_cmd[AddrLsb+6+IdxW +: paddr_width_p-6-IdxW];

    // Flag is raised on the edge that enters RESP, so it is already high during RESP.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_error <= 1'b0;
        end else if (w_do_access && w_oor && (w_is_rd || w_is_wr)) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    assign w_oor   = 1'b0;
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_mem_resp_server.sv
module tb_bp_mem_resp_server;

    localparam int unsigned MsgW   = 4 + 40 + 3 + 12 + 512;
    localparam int          Lat    = 4;
    localparam int          MemEls = 1024;
    localparam int          Bound  = 50;

    logic            clk;
    logic            rst_n;
    logic [MsgW-1:0] cmd;
    logic            v0, v1, y0, y1;
    logic            rdy0, rdy1, rv0, rv1, err0, err1;
    logic [MsgW-1:0] resp0, resp1;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_err = 1'b0;

    logic [511:0] mdl_mem [int];

    bp_mem_resp_server #(
        .paddr_width_p  (40),
        .block_width_p  (512),
        .payload_width_p(12),
        .mem_els_p      (MemEls),
        .latency_p      (Lat)
    ) u_dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .mem_cmd_i      (cmd),
        .mem_cmd_v_i    (v0),
        .mem_cmd_ready_o(rdy0),
        .mem_resp_o     (resp0),
        .mem_resp_v_o   (rv0),
        .mem_resp_yumi_i(y0),
        .error_o        (err0)
    );

    bp_mem_resp_server #(
        .paddr_width_p  (40),
        .block_width_p  (512),
        .payload_width_p(12),
        .mem_els_p      (MemEls),
        .latency_p      (1)
    ) u_dut1 (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .mem_cmd_i      (cmd),
        .mem_cmd_v_i    (v1),
        .mem_cmd_ready_o(rdy1),
        .mem_resp_o     (resp1),
        .mem_resp_v_o   (rv1),
        .mem_resp_yumi_i(y1),
        .error_o        (err1)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Reference: byte-addressed block store; reads replicate the aligned window.
    function automatic logic [511:0] mdl_access(input logic [3:0] t, input logic [39:0] a,
                                                input logic [2:0] s, input logic [511:0] d);
        longint unsigned addr;
        int idx, off, nb, base;
        logic [511:0] blk, r;
        bit oor;
        addr = 64'(a);
        idx  = int'((addr / 64) % MemEls);
        off  = int'(addr % 64);
        nb   = 1 << s;
        base = (off / nb) * nb;
        r    = '0;
        oor  = 1'b0;
`ifdef BP_MEM_RESP_SERVER_RANGE_CHECK_EN
        oor = (addr >= 64'(MemEls) * 64);
        if (oor && t <= 4'd3) exp_err = 1'b1;
`endif
        blk = mdl_mem.exists(idx) ? mdl_mem[idx] : '0;
        if (!oor && (t == 4'd0 || t == 4'd2)) begin
            for (int i = 0; i < 64; i++) r[i*8 +: 8] = blk[(base + i % nb)*8 +: 8];
        end else if (!oor && (t == 4'd1 || t == 4'd3)) begin
            for (int j = 0; j < nb; j++) blk[(base + j)*8 +: 8] = d[j*8 +: 8];
            mdl_mem[idx] = blk;
        end
        return r;
    endfunction

    // Issue one command on the selected DUT, measure edges from accept to valid, consume it.
    task automatic run_txn(input bit sel, input logic [3:0] t, input logic [39:0] a,
                           input logic [2:0] s, input logic [11:0] p, input logic [511:0] d,
                           output int lat, output logic [MsgW-1:0] resp);
        int k;
        cmd = {t, a, s, p, d};
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        k = 0;
        while (!(sel ? rdy1 : rdy0) && k < Bound) begin @(negedge clk); k++; end
        if (k >= Bound) begin
            v0 = 1'b0; v1 = 1'b0; lat = -1; resp = '0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        k = 0;
        while (!(sel ? rv1 : rv0) && k < Bound) begin @(negedge clk); k++; end
        lat  = (k >= Bound) ? -1 : k;
        resp = sel ? resp1 : resp0;
        if (k < Bound) begin
            if (sel) y1 = 1'b1; else y0 = 1'b1;
            @(negedge clk);
            y0 = 1'b0; y1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd = {4'h1, 40'h40, 3'd6, 12'h123, rand_blk()};
        v0 = 1'b1; v1 = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy0); end
        n_tests++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_v: got %b want 0", rv0); end
        n_tests++; if (resp0 !== '0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", resp0); end
        n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", err0); end
        n_tests++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_lat1: got %b want 0", rdy1); end
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", rdy0); end
        n_tests++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL idle_resp_v: got %b want 0", rv0); end
    endtask

    task automatic test_full_block();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] exp;
        logic [11:0] p;
        p = 12'($urandom);
        exp = mdl_access(4'h1, 40'h8000_0040, 3'd6, {64{8'hA5}});
        run_txn(1'b0, 4'h1, 40'h8000_0040, 3'd6, p, {64{8'hA5}}, lat, resp);
        n_tests++; if (lat !== Lat) begin n_fail++; $display("FAIL wr6_latency: got %0d want %0d", lat, Lat); end
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL wr6_data: got %h want %h", resp[511:0], exp); end
        n_tests++; if (resp[MsgW-1:512] !== {4'h1, 40'h8000_0040, 3'd6, p}) begin
            n_fail++; $display("FAIL wr6_header: got %h want %h", resp[MsgW-1:512], {4'h1, 40'h8000_0040, 3'd6, p}); end
        p = 12'($urandom);
        exp = mdl_access(4'h0, 40'h8000_0040, 3'd6, '0);
        run_txn(1'b0, 4'h0, 40'h8000_0040, 3'd6, p, rand_blk(), lat, resp);
        n_tests++; if (lat !== Lat) begin n_fail++; $display("FAIL rd6_latency: got %0d want %0d", lat, Lat); end
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL rd6_data: got %h want %h", resp[511:0], exp); end
        n_tests++; if (resp[MsgW-1:512] !== {4'h0, 40'h8000_0040, 3'd6, p}) begin
            n_fail++; $display("FAIL rd6_header: got %h want %h", resp[MsgW-1:512], {4'h0, 40'h8000_0040, 3'd6, p}); end
    endtask

    task automatic test_partial();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] exp;
        exp = mdl_access(4'h1, 40'h8000_0040, 3'd6, '0);
        run_txn(1'b0, 4'h1, 40'h8000_0040, 3'd6, 12'h0, '0, lat, resp);
        exp = mdl_access(4'h3, 40'h8000_0044, 3'd2, 512'h1234_5678_DEAD_BEEF);
        run_txn(1'b0, 4'h3, 40'h8000_0044, 3'd2, 12'h7, 512'h1234_5678_DEAD_BEEF, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL wr2_data: got %h want %h", resp[511:0], exp); end
        exp = mdl_access(4'h2, 40'h8000_0044, 3'd2, '0);
        run_txn(1'b0, 4'h2, 40'h8000_0044, 3'd2, 12'h8, '0, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL rd2_replicated: got %h want %h", resp[511:0], exp); end
        exp = mdl_access(4'h0, 40'h8000_0040, 3'd6, '0);
        run_txn(1'b0, 4'h0, 40'h8000_0040, 3'd6, 12'h9, '0, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL rd6_after_partial: got %h want %h", resp[511:0], exp); end
    endtask

    task automatic test_backpressure();
        int k;
        logic [511:0] d, e1, e2;
        logic [MsgW-1:0] held;
        d  = rand_blk();
        e1 = mdl_access(4'h1, 40'h300, 3'd6, d);
        cmd = {4'h1, 40'h300, 3'd6, 12'h0AA, d};
        v0 = 1'b1;
        k = 0;
        while (!rdy0 && k < Bound) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        cmd = {4'h0, 40'h300, 3'd6, 12'h0BB, 512'h0};
        k = 0;
        while (!rv0 && k < Bound) begin @(negedge clk); k++; end
        n_tests++; if (k !== Lat) begin n_fail++; $display("FAIL bp_first_latency: got %0d want %0d", k, Lat); end
        n_tests++; if (resp0 !== {4'h1, 40'h300, 3'd6, 12'h0AA, e1}) begin
            n_fail++; $display("FAIL bp_first_resp: got %h want %h", resp0, {4'h1, 40'h300, 3'd6, 12'h0AA, e1}); end
        held = resp0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++; if (rv0 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held c%0d: got %b want 1", c, rv0); end
            n_tests++; if (resp0 !== held) begin n_fail++; $display("FAIL bp_resp_stable c%0d: got %h want %h", c, resp0, held); end
            n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low c%0d: got %b want 0", c, rdy0); end
        end
        y0 = 1'b1;
        @(negedge clk);
        y0 = 1'b0;
        n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_yumi: got %b want 1", rdy0); end
        e2 = mdl_access(4'h0, 40'h300, 3'd6, '0);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        k = 0;
        while (!rv0 && k < Bound) begin @(negedge clk); k++; end
        n_tests++; if (k !== Lat) begin n_fail++; $display("FAIL bp_second_latency: got %0d want %0d", k, Lat); end
        n_tests++; if (resp0 !== {4'h0, 40'h300, 3'd6, 12'h0BB, e2}) begin
            n_fail++; $display("FAIL bp_second_resp: got %h want %h", resp0, {4'h0, 40'h300, 3'd6, 12'h0BB, e2}); end
        y0 = 1'b1;
        @(negedge clk);
        y0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] exp;
        exp = mdl_access(4'h1, 40'h140, 3'd6, {64{8'h5A}});
        run_txn(1'b0, 4'h1, 40'h140, 3'd6, 12'h1, {64{8'h5A}}, lat, resp);
        cmd = {4'h1, 40'h140, 3'd6, 12'h2, {64{8'hC3}}};
        v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL midreset_resp_v c%0d: got %b want 0", c, rv0); end
            n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL midreset_ready c%0d: got %b want 0", c, rdy0); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        exp = mdl_access(4'h0, 40'h140, 3'd6, '0);
        run_txn(1'b0, 4'h0, 40'h140, 3'd6, 12'h3, '0, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL midreset_old_data: got %h want %h", resp[511:0], exp); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] exp, pa, pb;
        pa = rand_blk();
        pb = rand_blk();
        exp = mdl_access(4'h1, 40'h0, 3'd6, pa);
        run_txn(1'b0, 4'h1, 40'h0, 3'd6, 12'h4, pa, lat, resp);
        exp = mdl_access(4'h1, 40'h1_0000, 3'd6, pb);
        run_txn(1'b0, 4'h1, 40'h1_0000, 3'd6, 12'h5, pb, lat, resp);
        n_tests++; if (err0 !== exp_err) begin n_fail++; $display("FAIL wrap_error: got %b want %b", err0, exp_err); end
        n_tests++; if (resp[MsgW-1:512] !== {4'h1, 40'h1_0000, 3'd6, 12'h5}) begin
            n_fail++; $display("FAIL wrap_header: got %h want %h", resp[MsgW-1:512], {4'h1, 40'h1_0000, 3'd6, 12'h5}); end
        exp = mdl_access(4'h0, 40'h0, 3'd6, '0);
        run_txn(1'b0, 4'h0, 40'h0, 3'd6, 12'h6, '0, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL wrap_block0: got %h want %h", resp[511:0], exp); end
        exp = mdl_access(4'h0, 40'h1_0000, 3'd6, '0);
        run_txn(1'b0, 4'h0, 40'h1_0000, 3'd6, 12'h7, '0, lat, resp);
        n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL wrap_read_hi: got %h want %h", resp[511:0], exp); end
    endtask

    task automatic test_random();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] exp, d;
        logic [3:0] t;
        logic [39:0] a;
        logic [2:0] s;
        logic [11:0] p;
        for (int b = 0; b < 8; b++) begin
            d = rand_blk();
            a = 40'(b * 64);
            exp = mdl_access(4'h1, a, 3'd6, d);
            run_txn(1'b0, 4'h1, a, 3'd6, 12'h0, d, lat, resp);
        end
        for (int n = 0; n < 40; n++) begin
            t = 4'($urandom_range(0, 5));
            a = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0,
                 10'($urandom_range(0, 7)), 6'($urandom)};
            s = 3'($urandom_range(0, 6));
            p = 12'($urandom);
            d = rand_blk();
            exp = mdl_access(t, a, s, d);
            run_txn(1'b0, t, a, s, p, d, lat, resp);
            n_tests++; if (lat !== Lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, Lat); end
            n_tests++; if (resp[511:0] !== exp) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h", n, resp[511:0], exp); end
            n_tests++; if (resp[MsgW-1:512] !== {t, a, s, p}) begin
                n_fail++; $display("FAIL rnd%0d_header: got %h want %h", n, resp[MsgW-1:512], {t, a, s, p}); end
        end
        n_tests++; if (err0 !== exp_err) begin n_fail++; $display("FAIL rnd_error: got %b want %b", err0, exp_err); end
    endtask

    // Latency-1 build: valid is seen at the first sample after the accept edge (0 extra edges).
    task automatic test_lat1();
        int lat;
        logic [MsgW-1:0] resp;
        logic [511:0] d;
        d = rand_blk();
        run_txn(1'b1, 4'h9, 40'h80, 3'd3, 12'hABC, d, lat, resp);
        n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL lat1_latency: got %0d want 0", lat); end
        n_tests++; if (resp[511:0] !== '0) begin n_fail++; $display("FAIL lat1_unknown_data: got %h want 0", resp[511:0]); end
        n_tests++; if (resp[MsgW-1:512] !== {4'h9, 40'h80, 3'd3, 12'hABC}) begin
            n_fail++; $display("FAIL lat1_header: got %h want %h", resp[MsgW-1:512], {4'h9, 40'h80, 3'd3, 12'hABC}); end
        run_txn(1'b1, 4'h1, 40'h80, 3'd6, 12'h1, {64{8'h3C}}, lat, resp);
        n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL lat1_wr_latency: got %0d want 0", lat); end
        run_txn(1'b1, 4'h0, 40'h80, 3'd6, 12'h2, '0, lat, resp);
        n_tests++; if (resp[511:0] !== {64{8'h3C}}) begin n_fail++; $display("FAIL lat1_rd_data: got %h want %h", resp[511:0], {64{8'h3C}}); end
        n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL lat1_error: got %b want 0", err1); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; cmd = '0;
        v0 = 1'b0; v1 = 1'b0; y0 = 1'b0; y1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_block();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        test_lat1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
